// File: rtl/pixel_write_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pixel_write_queue : clips drawer pixel writes to the screen, reduces colour
//                     depth and replays them to the VGA adapter via ready/plot.
// Revision 1.0
// ---------------------------------------------------------------------------
module pixel_write_queue #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int X_MAX    = 160,
  parameter int Y_MAX    = 120,
  parameter int COLOUR_W = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                draw_enable,
  input  logic [7:0]          x_in,
  input  logic [7:0]          y_in,
  input  logic [23:0]         rgb_in,
  input  logic                out_ready,
  output logic                plot,
  output logic [7:0]          x_out,
  output logic [7:0]          y_out,
  output logic [COLOUR_W-1:0] colour_out,
  output logic [ADDR_W:0]     fifo_level,
  output logic                overflow,
  output logic [15:0]         clip_count,
  input  logic                clear_flags
);

  localparam int              C          = COLOUR_W / 3;
  localparam int              ENTRY_W    = 16 + COLOUR_W;
  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] TWO        = (ADDR_W+1)'(2);

  typedef enum logic {EMPTY = 1'b0, PRESENT = 1'b1} state_t;

  state_t              state, state_next;
  logic [ENTRY_W-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0]   rd_ptr, wr_ptr;
  logic [ADDR_W:0]     level;
  logic                legal, pop, push_ok, clip_ev, ovf_ev, mem_empty;
  logic                load_new, load_head, mem_wr;
  logic [ENTRY_W-1:0]  new_entry, head_entry;
  logic                unused_rgb;

  assign legal      = ({1'b0, x_in} < 9'(X_MAX)) && ({1'b0, y_in} < 9'(Y_MAX));
  assign plot       = (state == PRESENT);
  assign pop        = plot & out_ready;
  assign push_ok    = draw_enable & legal & ((level != FULL_LEVEL) | pop);
  assign clip_ev    = draw_enable & ~legal;
  assign ovf_ev     = draw_enable & legal & ~push_ok;
  // The presented pixel lives in the output registers, so memory holds level-1 entries.
  assign mem_empty  = (level < TWO);
  assign new_entry  = {x_in, y_in, rgb_in[23 -: C], rgb_in[15 -: C], rgb_in[7 -: C]};
  assign head_entry = mem[rd_ptr];
  assign fifo_level = level;
  assign unused_rgb = ^rgb_in;

  always_comb begin
    state_next = state;
    load_new   = 1'b0;
    load_head  = 1'b0;
    mem_wr     = 1'b0;
    case (state)
      EMPTY: begin
        if (push_ok) begin
          state_next = PRESENT;
          load_new   = 1'b1;
        end
      end
      PRESENT: begin
        if (pop) begin
          if (!mem_empty) begin
            load_head = 1'b1;
            mem_wr    = push_ok;
          end else if (push_ok) begin
            load_new = 1'b1;
          end else begin
            state_next = EMPTY;
          end
        end else begin
          mem_wr = push_ok;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      clip_count <= '0;
    end else begin
      state <= state_next;
      if (load_new)
        {x_out, y_out, colour_out} <= new_entry;
      else if (load_head)
        {x_out, y_out, colour_out} <= head_entry;
      if (load_head)
        rd_ptr <= rd_ptr + 1'b1;
      if (mem_wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (push_ok && !pop)
        level <= level + 1'b1;
      else if (pop && !push_ok)
        level <= level - 1'b1;
      // A same-cycle event takes priority over clear_flags.
      if (ovf_ev)
        overflow <= 1'b1;
      else if (clear_flags)
        overflow <= 1'b0;
      if (clip_ev) begin
        if (clear_flags)
          clip_count <= 16'd1;
        else if (clip_count != 16'hFFFF)
          clip_count <= clip_count + 16'd1;
      end else if (clear_flags) begin
        clip_count <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr)
      mem[wr_ptr] <= new_entry;
  end

endmodule
`default_nettype wire
